game_fsm: RTL and testbench

Top-level game sequencer for the Tron datapath. It sits directly downstream of the score stage: it consumes the per-round crash events and the `Blue_W`/`Red_W` match-winner flags, and drives `Game_State` and `reset_round` back into score, movement and render. It paces title, countdown, play, round-end and game-over phases in whole video frames, using `frame_clk` synchronised into the `Clk` domain.

---
 rtl/tron_pkg.sv | 18 +
 rtl/game_fsm_sync_edge.sv | 29 ++
 rtl/game_fsm.sv | 106 ++++++++++
 tb/tb_game_fsm.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/tron_pkg.sv
// tron_pkg: shared game-state encodings and round-result codes for the Tron datapath
package tron_pkg;
    typedef enum logic [2:0] {
        TITLE     = 3'd0,
        NEW_GAME  = 3'd1,
        COUNTDOWN = 3'd2,
        PLAY      = 3'd3,
        ROUND_END = 3'd4,
        GAME_OVER = 3'd5
    } game_state_t;

    localparam logic [1:0] RR_NONE = 2'b00;
    localparam logic [1:0] RR_BLUE = 2'b01;
    localparam logic [1:0] RR_RED  = 2'b10;
    localparam logic [1:0] RR_DRAW = 2'b11;

    localparam int FRAME_RATE = 60;
endpackage

// File: rtl/game_fsm_sync_edge.sv
// sync_edge: 2-flop synchroniser with a one-cycle rising-edge pulse
module sync_edge (
    input  logic Clk,
    input  logic Reset_n,
    input  logic d,
    output logic rise
);
    logic s1, s2, s3, armed;
    logic [1:0] warm;

    // armed only after a genuine low is seen, so a level held through reset gives no edge
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            warm  <= 2'b00;
            armed <= 1'b0;
        end else begin
            s1    <= d;
            s2    <= s1;
            s3    <= s2;
            warm  <= {warm[0], 1'b1};
            armed <= armed | (warm[1] & ~s2);
        end
    end

    assign rise = s2 & ~s3 & armed;
endmodule

// File: rtl/game_fsm.sv
// game_fsm: frame-paced title/countdown/play/round-end/game-over sequencer
module game_fsm
    import tron_pkg::*;
#(
    parameter int COUNT_FRAMES = 180,
    parameter int END_FRAMES   = 120
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       start_key,
    input  logic       crash_blue,
    input  logic       crash_red,
    input  logic       Blue_W,
    input  logic       Red_W,
    output logic [2:0] Game_State,
    output logic       reset_round,
    output logic       round_active,
    output logic [1:0] countdown,
    output logic [1:0] round_result
);
    localparam int MAXF = COUNT_FRAMES > END_FRAMES ? COUNT_FRAMES : END_FRAMES;
    localparam int CW   = MAXF > 1 ? $clog2(MAXF) : 1;
    localparam logic [CW-1:0] CD_LOAD  = CW'(COUNT_FRAMES - 1);
    localparam logic [CW-1:0] END_LOAD = CW'(END_FRAMES - 1);
    localparam logic [CW-1:0] T3       = CW'(2 * COUNT_FRAMES / 3);
    localparam logic [CW-1:0] T2       = CW'(COUNT_FRAMES / 3);

    game_state_t   state;
    logic [CW-1:0] cnt;
    logic          frame_tick, start_rise;

    sync_edge u_frame (.Clk(Clk), .Reset_n(Reset_n), .d(frame_clk), .rise(frame_tick));
    sync_edge u_start (.Clk(Clk), .Reset_n(Reset_n), .d(start_key), .rise(start_rise));

    function automatic logic [1:0] secs(input logic [CW-1:0] c);
        return c >= T3 ? 2'd3 : c >= T2 ? 2'd2 : 2'd1;
    endfunction

    // outputs are computed from the next state so they change together with Game_State
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= TITLE;
            reset_round  <= 1'b0;
            round_active <= 1'b0;
            countdown    <= 2'd0;
            round_result <= RR_NONE;
            cnt          <= '0;
        end else begin
            reset_round  <= 1'b0;
            round_active <= 1'b0;
            countdown    <= 2'd0;
            case (state)
                TITLE, GAME_OVER: begin
                    if (start_rise) begin
                        state        <= NEW_GAME;
                        reset_round  <= 1'b1;
                        round_result <= RR_NONE;
                    end
                end
                NEW_GAME: begin
                    state     <= COUNTDOWN;
                    cnt       <= CD_LOAD;
                    countdown <= secs(CD_LOAD);
                end
                COUNTDOWN: begin
                    if (!frame_tick) begin
                        countdown <= secs(cnt);
                    end else if (cnt == '0) begin
                        state        <= PLAY;
                        round_active <= 1'b1;
                    end else begin
                        cnt       <= cnt - CW'(1);
                        countdown <= secs(cnt - CW'(1));
                    end
                end
                PLAY: begin
                    if (crash_blue | crash_red) begin
                        state        <= ROUND_END;
                        round_result <= {crash_red, crash_blue};
                        cnt          <= END_LOAD;
                    end else begin
                        round_active <= 1'b1;
                    end
                end
                ROUND_END: begin
                    if (frame_tick) begin
                        if (cnt != '0) begin
                            cnt <= cnt - CW'(1);
                        end else if (Blue_W | Red_W) begin
                            state <= GAME_OVER;
                        end else begin
                            state       <= COUNTDOWN;
                            reset_round <= 1'b1;
                            cnt         <= CD_LOAD;
                            countdown   <= secs(CD_LOAD);
                        end
                    end
                end
                default: state <= TITLE;
            endcase
        end
    end

    assign Game_State = state;
endmodule

// File: tb/tb_game_fsm.sv
// tb_game_fsm: directed and randomized checks of game_fsm against a behavioural model
module tb_game_fsm;
    import tron_pkg::*;
    localparam int CF = 6;
    localparam int EF = 4;

    logic Clk = 0, Reset_n = 0, frame_clk = 0, start_key = 0;
    logic crash_blue = 0, crash_red = 0, Blue_W = 0, Red_W = 0;
    logic [2:0] Game_State;
    logic       reset_round, round_active;
    logic [1:0] countdown, round_result;
    int errors = 0, checks = 0, pulses = 0;

    always #10 Clk = ~Clk;

    game_fsm #(.COUNT_FRAMES(CF), .END_FRAMES(EF)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .start_key(start_key),
        .crash_blue(crash_blue), .crash_red(crash_red), .Blue_W(Blue_W), .Red_W(Red_W),
        .Game_State(Game_State), .reset_round(reset_round), .round_active(round_active),
        .countdown(countdown), .round_result(round_result)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model: input history since reset, then the game rules on abstract state numbers
    bit fh[0:16383], sh[0:16383];
    int n, fzero, szero, ms, left, m_rr;
    bit m_pulse, ft, st;

    function automatic bit seen_rise(bit a2, bit a3, int z, int k);
        return k >= 4 && a2 && !a3 && z > 0 && z <= k - 3;
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            n = 0; fzero = 0; szero = 0; ms = 0; left = 0; m_rr = 0; m_pulse = 0;
        end else begin
            n++;
            fh[n] = frame_clk;
            sh[n] = start_key;
            if (!frame_clk && fzero == 0) fzero = n;
            if (!start_key && szero == 0) szero = n;
            ft = n >= 4 ? seen_rise(fh[n-2], fh[n-3], fzero, n) : 1'b0;
            st = n >= 4 ? seen_rise(sh[n-2], sh[n-3], szero, n) : 1'b0;
            m_pulse = 0;
            case (ms)
                0, 5: if (st) begin ms = 1; m_rr = 0; m_pulse = 1; end
                1: begin ms = 2; left = CF - 1; end
                2: if (ft) begin if (left == 0) ms = 3; else left--; end
                3: if (crash_blue || crash_red) begin ms = 4; m_rr = {crash_red, crash_blue}; left = EF - 1; end
                4: if (ft) begin
                    if (left > 0) left--;
                    else if (Blue_W || Red_W) ms = 5;
                    else begin ms = 2; left = CF - 1; m_pulse = 1; end
                end
                default: ms = 0;
            endcase
        end
    end

    always @(negedge Clk) begin
        if (Reset_n) begin
            chk("state", Game_State, ms);
            chk("reset_round", reset_round, m_pulse);
            chk("round_active", round_active, ms == 3);
            chk("countdown", countdown, ms == 2 ? 3 - (CF - 1 - left) * 3 / CF : 0);
            chk("round_result", round_result, m_rr);
            if (reset_round) pulses++;
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge Clk);
    endtask

    task automatic frame_pulse();
        frame_clk = 1; cyc(2); frame_clk = 0; cyc(4);
    endtask

    task automatic wait_state(input int s, input int lim);
        int i = 0;
        while (Game_State !== 3'(s) && i < lim) begin
            @(negedge Clk);
            i++;
        end
        chk("wait_state", Game_State, s);
    endtask

    task automatic do_reset();
        Reset_n = 0; cyc(3); Reset_n = 1;
    endtask

    int exp_cd[5] = '{3, 2, 2, 1, 1};
    int p0;

    initial begin
        start_key = 1;
        @(negedge Clk);
        do_reset();
        chk("rst_state", Game_State, 0);
        chk("rst_reset_round", reset_round, 0);
        chk("rst_active", round_active, 0);
        chk("rst_countdown", countdown, 0);
        chk("rst_result", round_result, 0);
        cyc(10);
        chk("held_start_no_edge", Game_State, 0);
        start_key = 0; cyc(5);

        start_key = 1;
        wait_state(1, 10);
        chk("new_game_pulse", reset_round, 1);
        @(negedge Clk);
        chk("to_countdown", Game_State, 2);
        chk("cd_first", countdown, 3);
        chk("pulse_one_cycle", reset_round, 0);
        start_key = 0; cyc(3);
        for (int i = 0; i < 5; i++) begin
            frame_pulse();
            chk("cd_seq", countdown, exp_cd[i]);
        end
        frame_pulse();
        chk("play_state", Game_State, 3);
        chk("play_active", round_active, 1);

        crash_blue = 1; crash_red = 1; cyc(1); crash_blue = 0; crash_red = 0;
        chk("draw_state", Game_State, 4);
        chk("draw_result", round_result, 3);
        crash_blue = 1; cyc(1); crash_blue = 0;
        chk("crash_ignored", round_result, 3);

        p0 = pulses;
        repeat (EF) frame_pulse();
        chk("round_restart_pulses", pulses - p0, 1);
        chk("back_to_countdown", Game_State, 2);
        repeat (CF) frame_pulse();
        chk("play_again", Game_State, 3);
        crash_blue = 1; cyc(1); crash_blue = 0;
        chk("blue_result", round_result, 1);
        Red_W = 1; p0 = pulses;
        repeat (EF) frame_pulse();
        chk("game_over", Game_State, 5);
        chk("game_over_no_pulse", pulses - p0, 0);
        chk("game_over_result", round_result, 1);

        Red_W = 0; start_key = 1;
        wait_state(1, 10);
        @(negedge Clk);
        chk("new_game_one_cycle", Game_State, 2);
        start_key = 0; cyc(3);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) frame_clk = ~frame_clk;
            if ($urandom_range(0, 9) == 0) start_key = ~start_key;
            crash_blue = $urandom_range(0, 39) == 0;
            crash_red  = $urandom_range(0, 39) == 0;
            if ($urandom_range(0, 49) == 0) Blue_W = 1'($urandom);
            if ($urandom_range(0, 49) == 0) Red_W = 1'($urandom);
            @(negedge Clk);
        end

        frame_clk = 0; start_key = 0; crash_blue = 0; crash_red = 0; Blue_W = 0; Red_W = 0;
        do_reset();
        cyc(5);
        start_key = 1;
        wait_state(2, 20);
        start_key = 0;
        repeat (CF) frame_pulse();
        chk("pre_reset_play", Game_State, 3);
        #3 Reset_n = 0;
        #1;
        chk("async_state", Game_State, 0);
        chk("async_active", round_active, 0);
        chk("async_reset_round", reset_round, 0);
        @(negedge Clk);
        Reset_n = 1;
        cyc(2);
        chk("post_reset_title", Game_State, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
